poly1305_serial_verifier: RTL and testbench

//  Receive-side counterpart of the Poly1305 serial tag encoder. It absorbs a message one
//  16-byte block per cycle over a valid/ready stream and recomputes the tag from the
//  one-time key. It compares that tag against an expected tag and reports pass or fail.
//  It sits behind the ChaCha20 decrypt path and gates plaintext release on tag_ok.

---
 rtl/poly1305_serial_verifier.sv | 99 +++++++++
 tb/tb_poly1305_serial_verifier.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/poly1305_serial_verifier.sv
// poly1305_serial_verifier: recompute a Poly1305 tag one block per cycle and check it; POLY1305_VERIFIER_FAIL_COUNT_EN adds a saturating fail counter
module poly1305_serial_verifier #(
  parameter int FAIL_COUNT_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        clear_n,
  input  logic                        start,
  input  logic [255:0]                key,
  input  logic [127:0]                expected_tag,
  input  logic                        message_empty,
  input  logic                        block_valid,
  output logic                        block_ready,
  input  logic [127:0]                block_data,
  input  logic [3:0]                  number_of_input_bytes_minus_one,
  input  logic                        block_last,
  output logic                        busy,
  output logic                        done,
  output logic                        tag_ok,
  output logic [FAIL_COUNT_WIDTH-1:0] fail_count
);
  localparam logic [130:0] P = 131'h3_ffff_ffff_ffff_ffff_ffff_ffff_ffff_fffb;
  localparam logic [127:0] CLAMP = 128'h0fff_fffc_0fff_fffc_0fff_fffc_0fff_ffff;
  typedef enum logic [1:0] {IDLE, ABSORB, FINAL, REPORT} state_t;
  state_t state;
  logic [127:0] r, s, exp_tag, tag;
  logic [129:0] acc;
  logic accept;
  function automatic logic [127:0] poly1305_clamp(input logic [127:0] k);
    return k & CLAMP;
  endfunction
  // acc stays fully reduced below P, so one fold plus one conditional subtract suffices
  function automatic logic [129:0] poly1305_block(input logic [127:0] d, input logic [3:0] nm1,
                                                  input logic [129:0] h, input logic [127:0] rr);
    logic [128:0] pad;
    logic [130:0] sum, t, u;
    logic [254:0] prod;
    pad = 129'd1 << {{1'b0, nm1} + 5'd1, 3'b000};
    sum = 131'(h) + 131'(pad) + 131'(d & 128'(pad - 129'd1));
    prod = 255'(sum) * 255'(rr);
    t = 131'(prod[129:0]) + 131'(prod[254:130]) * 131'd5;
    u = 131'(t[129:0]) + (t[130] ? 131'd5 : 131'd0);
    return 130'((u >= P) ? u - P : u);
  endfunction
  assign accept = block_valid && block_ready;
  // verification FSM with registered handshake and result outputs
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      r <= '0;
      s <= '0;
      exp_tag <= '0;
      tag <= '0;
      acc <= '0;
      block_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      tag_ok <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          r <= poly1305_clamp(key[127:0]);
          s <= key[255:128];
          exp_tag <= expected_tag;
          acc <= '0;
          tag_ok <= 1'b0;
          busy <= 1'b1;
          block_ready <= !message_empty;
          state <= message_empty ? FINAL : ABSORB;
        end
        ABSORB: if (accept) begin
          acc <= poly1305_block(block_data, number_of_input_bytes_minus_one, acc, r);
          block_ready <= !block_last;
          state <= block_last ? FINAL : ABSORB;
        end
        FINAL: begin
          tag <= acc[127:0] + s;
          state <= REPORT;
        end
        REPORT: begin
          done <= 1'b1;
          tag_ok <= tag == exp_tag;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef POLY1305_VERIFIER_FAIL_COUNT_EN
  // count failed reports, sticking at all-ones until reset
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) fail_count <= '0;
    else if (state == REPORT && tag != exp_tag && !(&fail_count)) fail_count <= fail_count + FAIL_COUNT_WIDTH'(1);
  end
`else
  assign fail_count = '0;
`endif
endmodule

// File: tb/tb_poly1305_serial_verifier.sv
// tb_poly1305_serial_verifier: randomized self-checking bench against a bit-serial Poly1305 model
module tb_poly1305_serial_verifier;
`ifdef POLY1305_VERIFIER_FAIL_COUNT_EN
  localparam int FCW = 6;
  localparam bit FC_EN = 1'b1;
`else
  localparam int FCW = 16;
  localparam bit FC_EN = 1'b0;
`endif
  localparam logic [130:0] P = 131'h3_ffff_ffff_ffff_ffff_ffff_ffff_ffff_fffb;
  localparam logic [255:0] RFC_KEY = {128'h1bf54941aff6bf4afdb20dfb8a800301, 128'ha806d542fe52447f336d555778bed685};
  localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;
  logic clock = 1'b0, clear_n = 1'b0, start = 1'b0, message_empty = 1'b0;
  logic block_valid = 1'b0, block_last = 1'b0;
  logic [255:0] key = '0;
  logic [127:0] expected_tag = '0, block_data = '0;
  logic [3:0] nm1 = '0;
  logic block_ready, busy, done, tag_ok;
  logic [FCW-1:0] fail_count;
  int tests = 0, fails = 0, nfail = 0;
  logic [7:0] mb [0:255];

  poly1305_serial_verifier #(.FAIL_COUNT_WIDTH(FCW)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .key(key), .expected_tag(expected_tag),
    .message_empty(message_empty), .block_valid(block_valid), .block_ready(block_ready),
    .block_data(block_data), .number_of_input_bytes_minus_one(nm1), .block_last(block_last),
    .busy(busy), .done(done), .tag_ok(tag_ok), .fail_count(fail_count));

  always #5 clock = ~clock;

  function automatic logic [130:0] addmod(input logic [130:0] a, input logic [130:0] b);
    logic [131:0] t;
    t = 132'(a) + 132'(b);
    return 131'((t >= 132'(P)) ? t - 132'(P) : t);
  endfunction

  function automatic logic [130:0] mulmod(input logic [130:0] a, input logic [130:0] b);
    logic [130:0] res = '0;
    for (int i = 130; i >= 0; i--) begin
      res = addmod(res, res);
      if (b[i]) res = addmod(res, a);
    end
    return res;
  endfunction

  function automatic logic [127:0] model_tag(input logic [255:0] k, input int len);
    logic [130:0] h = '0, m, rr;
    rr = {3'b0, k[127:0] & 128'h0ffffffc0ffffffc0ffffffc0fffffff};
    for (int b = 0; b * 16 < len; b++) begin
      int n = (len - 16 * b > 16) ? 16 : len - 16 * b;
      m = '0;
      for (int j = 0; j < n; j++) m[8 * j +: 8] = mb[16 * b + j];
      m[8 * n] = 1'b1;
      h = mulmod(addmod(h, m), rr);
    end
    return h[127:0] + k[255:128];
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [FCW-1:0] exp_fc(input int n);
    if (!FC_EN) return '0;
    return (n >= (1 << FCW) - 1) ? '1 : FCW'(n);
  endfunction

  task automatic load_rfc();
    string m = "Cryptographic Forum Research Group";
    for (int i = 0; i < 34; i++) mb[i] = m[i];
  endtask

  task automatic load_rand(input int len);
    for (int i = 0; i < len; i++) mb[i] = 8'($urandom);
  endtask

  task automatic do_start(input logic [255:0] k, input logic [127:0] et, input bit empty);
    start = 1'b1; key = k; expected_tag = et; message_empty = empty;
    @(posedge clock); #1;
    start = 1'b0; message_empty = 1'b0;
  endtask

  task automatic send_block(input int blk, input int len, input int stall, input bit poke, output bit rdy_ok);
    int n = (len - 16 * blk > 16) ? 16 : len - 16 * blk;
    int w = 0;
    rdy_ok = 1'b1;
    for (int c = 0; c < stall; c++) begin
      block_valid = 1'b0; block_last = 1'b1; start = poke;
      if (poke) begin key = rnd256(); expected_tag = rnd256()[127:0]; message_empty = 1'($urandom); end
      if (!block_ready) rdy_ok = 1'b0;
      @(posedge clock); #1;
    end
    start = 1'b0; message_empty = 1'b0;
    for (int j = 0; j < 16; j++) block_data[8 * j +: 8] = (j < n) ? mb[16 * blk + j] : 8'($urandom);
    nm1 = 4'(n - 1); block_last = (16 * (blk + 1) >= len); block_valid = 1'b1;
    while (!block_ready && w < 8) begin @(posedge clock); #1; w++; end
    if (!block_ready) rdy_ok = 1'b0;
    @(posedge clock); #1;
    block_valid = 1'b0; block_last = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit ok, output bit saw);
    lat = 0; saw = 1'b0;
    while (!done && lat < 10) begin
      if (block_ready) saw = 1'b1;
      @(posedge clock); #1; lat++;
    end
    if (block_ready) saw = 1'b1;
    ok = tag_ok;
  endtask

  task automatic run_msg(input logic [255:0] k, input logic [127:0] et, input int len, input int stall,
                         input bit poke, output int lat, output bit ok, output bit rdy_ok, output bit saw);
    bit r1;
    do_start(k, et, len == 0);
    rdy_ok = 1'b1;
    for (int b = 0; b * 16 < len; b++) begin
      send_block(b, len, (b > 0) ? stall : 0, poke, r1);
      rdy_ok &= r1;
    end
    wait_done(lat, ok, saw);
  endtask

  task automatic test_reset();
    #12;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy got %0b want 0", busy); end
    tests++; if (block_ready !== 1'b0) begin fails++; $display("FAIL reset block_ready got %0b want 0", block_ready); end
    tests++; if (done !== 1'b0 || tag_ok !== 1'b0) begin fails++; $display("FAIL reset done/tag_ok got %0b/%0b want 0/0", done, tag_ok); end
    tests++; if (fail_count !== '0) begin fails++; $display("FAIL reset fail_count got %0d want 0", fail_count); end
    @(negedge clock) clear_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_rfc(input string name, input logic [127:0] et, input int stall, input bit poke);
    int lat; bit ok, rdy, saw, want;
    want = (et == RFC_TAG);
    load_rfc();
    run_msg(RFC_KEY, et, 34, stall, poke, lat, ok, rdy, saw);
    if (!want) nfail++;
    tests++; if (lat !== 2) begin fails++; $display("FAIL %s latency got %0d want 2", name, lat); end
    tests++; if (ok !== want) begin fails++; $display("FAIL %s tag_ok got %0b want %0b", name, ok, want); end
    tests++; if (rdy !== 1'b1 || saw !== 1'b0) begin fails++; $display("FAIL %s ready got stall_ok=%0b after_last=%0b want 1/0", name, rdy, saw); end
    tests++; if (fail_count !== exp_fc(nfail)) begin fails++; $display("FAIL %s fail_count got %0d want %0d", name, fail_count, exp_fc(nfail)); end
    @(posedge clock); #1;
    tests++; if (done !== 1'b0 || tag_ok !== want) begin fails++; $display("FAIL %s pulse/hold got done=%0b tag_ok=%0b want 0/%0b", name, done, tag_ok, want); end
  endtask

  task automatic test_empty();
    int lat; bit ok, rdy, saw;
    logic [255:0] k = rnd256();
    run_msg(k, k[255:128], 0, 0, 0, lat, ok, rdy, saw);
    tests++; if (lat !== 2) begin fails++; $display("FAIL empty latency got %0d want 2", lat); end
    tests++; if (ok !== 1'b1 || saw !== 1'b0) begin fails++; $display("FAIL empty got tag_ok=%0b ready_seen=%0b want 1/0", ok, saw); end
  endtask

  task automatic test_reset_mid();
    bit r1;
    load_rfc();
    do_start(RFC_KEY, RFC_TAG, 1'b0);
    send_block(0, 34, 0, 0, r1);
    send_block(1, 34, 0, 0, r1);
    clear_n = 1'b0; #1;
    tests++; if (busy !== 1'b0 || block_ready !== 1'b0 || tag_ok !== 1'b0) begin
      fails++; $display("FAIL reset_mid got busy=%0b ready=%0b tag_ok=%0b want 0/0/0", busy, block_ready, tag_ok); end
    nfail = 0;
    tests++; if (fail_count !== '0) begin fails++; $display("FAIL reset_mid fail_count got %0d want 0", fail_count); end
    @(negedge clock) clear_n = 1'b1;
    @(posedge clock); #1;
    test_rfc("after_reset", RFC_TAG, 0, 0);
  endtask

  task automatic test_random(input int iters, input string name);
    int lat, len, stall; bit ok, rdy, saw, bad;
    logic [255:0] k; logic [127:0] t, et;
    for (int i = 0; i < iters; i++) begin
      k = rnd256(); len = $urandom_range(0, 70); load_rand(len);
      t = model_tag(k, len);
      bad = 1'($urandom); et = bad ? t ^ (128'd1 << $urandom_range(0, 127)) : t;
      stall = $urandom_range(0, 2);
      run_msg(k, et, len, stall, 0, lat, ok, rdy, saw);
      if (bad) nfail++;
      tests++; if (lat !== 2 || ok !== !bad || rdy !== 1'b1) begin
        fails++; $display("FAIL %s[%0d] len=%0d got lat=%0d tag_ok=%0b rdy=%0b want 2/%0b/1", name, i, len, lat, ok, rdy, !bad); end
      tests++; if (fail_count !== exp_fc(nfail)) begin
        fails++; $display("FAIL %s[%0d] fail_count got %0d want %0d", name, i, fail_count, exp_fc(nfail)); end
    end
  endtask

`ifdef POLY1305_VERIFIER_FAIL_COUNT_EN
  task automatic test_saturate();
    int lat; bit ok, rdy, saw;
    logic [255:0] k = rnd256();
    for (int i = 0; i < (1 << FCW) + 3; i++) begin
      run_msg(k, k[255:128] ^ 128'd1, 0, 0, 0, lat, ok, rdy, saw);
      nfail++;
    end
    tests++; if (fail_count !== {FCW{1'b1}}) begin fails++; $display("FAIL saturate fail_count got %0h want all ones", fail_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_rfc("rfc", RFC_TAG, 0, 0);
    test_rfc("bad_tag", RFC_TAG ^ 128'd1, 0, 0);
    test_rfc("stall", RFC_TAG, 5, 0);
    test_empty();
    test_reset_mid();
    test_rfc("start_ignored", RFC_TAG, 3, 1);
    test_random(4, "back_to_back");
    test_random(20, "random");
`ifdef POLY1305_VERIFIER_FAIL_COUNT_EN
    test_saturate();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
